// File: rtl/regfile_req_ctrl.sv
// Requester-side controller for a single-port, 1-cycle-latency regfile macro; reads return in order through a credit-limited response FIFO.
// Optional macro RFM_PERF_CNT_EN adds accepted read/write counters (perf_rd_o, perf_wr_o).
module regfile_req_ctrl #(
  parameter int BITS       = 64,
  parameter int WORD_DEPTH = 128,
  parameter int ADDR_WIDTH = $clog2(WORD_DEPTH),
  parameter int RSP_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [BITS-1:0]       req_wd_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [BITS-1:0]       rsp_data_o,
  output logic [ADDR_WIDTH-1:0] rsp_addr_o,
  output logic                  mem_ce_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [BITS-1:0]       mem_wd_o,
  input  logic [BITS-1:0]       mem_rd_i,
  output logic                  busy_o
`ifdef RFM_PERF_CNT_EN
  ,
  output logic [31:0]           perf_rd_o,
  output logic [31:0]           perf_wr_o
`endif
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  // One spare bit so count + inflight never overflows the compare.
  localparam int CW = $clog2(RSP_DEPTH + 1) + 1;

  logic [CW-1:0]         count;
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] infl_addr;
  logic [BITS-1:0]       data_q [RSP_DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [RSP_DEPTH];
  logic                  acc;
  logic                  rd_issue;
  logic                  push;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Credits cover both queued responses and the read still in the macro.
  assign req_ready_o = rst_n && ((count + CW'(inflight)) < CW'(RSP_DEPTH));
  assign acc         = req_valid_i & req_ready_o;
  assign rd_issue    = acc & ~req_we_i;

  assign mem_ce_o    = acc;
  assign mem_we_o    = acc & req_we_i;
  assign mem_addr_o  = acc ? req_addr_i : '0;
  assign mem_wd_o    = (acc & req_we_i) ? req_wd_i : '0;

  assign push        = inflight;
  assign rsp_valid_o = (count != '0);
  assign pop         = rsp_valid_o & rsp_ready_i;
  assign rsp_data_o  = data_q[rptr];
  assign rsp_addr_o  = addr_q[rptr];
  assign busy_o      = inflight | rsp_valid_o;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Payload storage needs no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (rd_issue) infl_addr <= req_addr_i;
    if (push) begin
      data_q[wptr] <= mem_rd_i;
      addr_q[wptr] <= infl_addr;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push && count == CW'(RSP_DEPTH)));

`ifdef RFM_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_rd_o <= '0;
      perf_wr_o <= '0;
    end else begin
      if (rd_issue)         perf_rd_o <= perf_rd_o + 32'd1;
      if (acc & req_we_i)   perf_wr_o <= perf_wr_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_req_ctrl.sv
// Bench for regfile_req_ctrl: directed scenarios plus random traffic against a queue/array reference model.
module tb_regfile_req_ctrl;
  localparam int BITS  = 64;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int RD    = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            req_valid_i;
  logic            req_ready_o;
  logic            req_we_i;
  logic [AW-1:0]   req_addr_i;
  logic [BITS-1:0] req_wd_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic [BITS-1:0] rsp_data_o;
  logic [AW-1:0]   rsp_addr_o;
  logic            mem_ce_o;
  logic            mem_we_o;
  logic [AW-1:0]   mem_addr_o;
  logic [BITS-1:0] mem_wd_o;
  logic [BITS-1:0] mem_rd_i;
  logic            busy_o;
`ifdef RFM_PERF_CNT_EN
  logic [31:0]     perf_rd_o;
  logic [31:0]     perf_wr_o;
`endif

  always #5 clk = ~clk;

  regfile_req_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_addr_i(req_addr_i), .req_wd_i(req_wd_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_addr_o(rsp_addr_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o), .mem_rd_i(mem_rd_i), .busy_o(busy_o)
`ifdef RFM_PERF_CNT_EN
    , .perf_rd_o(perf_rd_o), .perf_wr_o(perf_wr_o)
`endif
  );

  // Macro behaviour: OR-merging writes, 1-cycle read latency, X when not selected.
  logic            clr_mem;
  logic [BITS-1:0] macro_mem [DEPTH];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < DEPTH; i++) macro_mem[i] <= '0;
    end else if (mem_ce_o) begin
      if (mem_we_o) macro_mem[mem_addr_o] <= macro_mem[mem_addr_o] | mem_wd_o;
      else          mem_rd_i <= macro_mem[mem_addr_o];
    end else begin
      mem_rd_i <= 'x;
    end
  end

  typedef struct {
    logic [AW-1:0]   a;
    logic [BITS-1:0] d;
    int              c;
  } ent_t;

  ent_t            q[$];
  logic [BITS-1:0] shadow [DEPTH];
  int              cyc = 0;
  int              perf_rd_m = 0;
  int              perf_wr_m = 0;
  bit              rst_seen = 0;

  int              n_chk = 0;
  int              n_fail = 0;
  logic            acc_obs;
  int              ce_cnt = 0;
  int              rsp_cnt = 0;
  int              vld_cnt = 0;
  logic [BITS-1:0] last_data;
  logic [AW-1:0]   last_addr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check #1 later, advance the model at posedge.
  task automatic step(input logic v, input logic we, input logic [AW-1:0] a,
                      input logic [BITS-1:0] wd, input logic rr, input logic rn);
    logic rdy_e, acc_e, vld_e, pop_e;
    int   c0;
    @(negedge clk);
    req_valid_i = v; req_we_i = we; req_addr_i = a; req_wd_i = wd;
    rsp_ready_i = rr; rst_n = rn;
    #1;
    c0    = cyc;
    rdy_e = rn && (q.size() < RD);
    acc_e = v && rdy_e;
    vld_e = (q.size() != 0) && (c0 >= q[0].c + 2);
    chk("req_ready", 64'(req_ready_o), 64'(rdy_e));
    chk("mem_ce",    64'(mem_ce_o),    64'(acc_e));
    chk("mem_we",    64'(mem_we_o),    64'(acc_e && we));
    chk("mem_addr",  64'(mem_addr_o),  acc_e ? 64'(a) : 64'd0);
    chk("mem_wd",    mem_wd_o,         (acc_e && we) ? wd : 64'd0);
    if (rst_seen) begin
      chk("rsp_valid", 64'(rsp_valid_o), 64'(vld_e));
      chk("busy",      64'(busy_o),      64'(q.size() != 0));
      if (vld_e) begin
        chk("rsp_addr", 64'(rsp_addr_o), 64'(q[0].a));
        chk("rsp_data", rsp_data_o,      q[0].d);
      end
`ifdef RFM_PERF_CNT_EN
      chk("perf_rd", 64'(perf_rd_o), 64'(32'(perf_rd_m)));
      chk("perf_wr", 64'(perf_wr_o), 64'(32'(perf_wr_m)));
`endif
      if (rsp_valid_o) vld_cnt++;
    end
    acc_obs = req_valid_i && req_ready_o;
    if (mem_ce_o) ce_cnt++;
    if (rn && rsp_valid_o && rr) begin
      rsp_cnt++;
      last_data = rsp_data_o;
      last_addr = rsp_addr_o;
    end
    pop_e = rn && vld_e && rr;
    @(posedge clk);
    cyc++;
    if (!rn) begin
      q.delete();
      perf_rd_m = 0;
      perf_wr_m = 0;
      rst_seen  = 1;
    end else begin
      if (pop_e) void'(q.pop_front());
      if (acc_e) begin
        if (we) begin
          shadow[a] = shadow[a] | wd;
          perf_wr_m++;
        end else begin
          q.push_back('{a, shadow[a], c0});
          perf_rd_m++;
        end
      end
    end
  endtask

  int acc_cnt;
  int idx;
  int base;
  logic [BITS-1:0] rwd;

  initial begin
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    clr_mem = 1'b1; rst_n = 1'b0; req_valid_i = 1'b0; req_we_i = 1'b0;
    req_addr_i = '0; req_wd_i = '0; rsp_ready_i = 1'b1;

    // Reset with a request pending, then release
    step(1'b1, 1'b0, 7'd3, 64'd0, 1'b1, 1'b0);
    clr_mem = 1'b0;
    step(1'b1, 1'b1, 7'd9, 64'hDEAD, 1'b1, 1'b0);
    step(1'b0, 1'b0, 7'd0, 64'd0, 1'b1, 1'b1);

    // Write then immediate read of the same address
    step(1'b1, 1'b1, 7'd5, 64'h00FF, 1'b1, 1'b1);
    step(1'b1, 1'b0, 7'd5, 64'd0,    1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
    chk("t2_data", last_data, 64'h00FF);
    chk("t2_addr", 64'(last_addr), 64'd5);

    // OR merge
    step(1'b1, 1'b1, 7'd7, 64'h0F00, 1'b1, 1'b1);
    step(1'b1, 1'b1, 7'd7, 64'h00F0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 7'd7, 64'd0,    1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
    chk("t3_data", last_data, 64'h0FF0);

    // Backpressure: 5 reads offered with rsp_ready low
    acc_cnt = 0; idx = 0;
    repeat (8) begin
      step(idx < 5, 1'b0, 7'(20 + idx), 64'd0, 1'b0, 1'b1);
      if (acc_obs) begin idx++; acc_cnt++; end
    end
    chk("t4_accepted", 64'(acc_cnt), 64'd3);
    base = rsp_cnt;
    repeat (20) begin
      step(idx < 5, 1'b0, 7'(20 + idx), 64'd0, 1'b1, 1'b1);
      if (acc_obs) idx++;
    end
    chk("t4_rsp_total", 64'(rsp_cnt - base), 64'd5);

    // Throughput: 64 back-to-back reads
    acc_cnt = 0; base = rsp_cnt; idx = ce_cnt;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b0, 7'(i), 64'd0, 1'b1, 1'b1);
      if (acc_obs) acc_cnt++;
    end
    repeat (3) step(1'b0, 1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
    chk("t5_accepted", 64'(acc_cnt), 64'd64);
    chk("t5_ce_cycles", 64'(ce_cnt - idx), 64'd64);
    chk("t5_rsp", 64'(rsp_cnt - base), 64'd64);

    // Reset with one read in flight and two queued
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 7'(40 + i), 64'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 7'd0, 64'd0, 1'b0, 1'b0);
    base = vld_cnt;
    repeat (6) step(1'b0, 1'b0, 7'd0, 64'd0, 1'b1, 1'b1);
    chk("t6_no_rsp", 64'(vld_cnt - base), 64'd0);

    // Random traffic, including occasional resets
    repeat (3000) begin
      rwd = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      step(($urandom % 10) < 7, ($urandom % 10) < 4, 7'($urandom_range(0, 15)), rwd,
           ($urandom % 10) < 7, ($urandom % 300) != 0);
    end
    repeat (6) step(1'b0, 1'b0, 7'd0, 64'd0, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
